// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-clock divider, h/v counters,
// and sync/blank/coordinate outputs registered from the next counter values.
module vga_timing_gen #(
   parameter int unsigned H_DISPLAY = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_DISPLAY = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33,
   parameter int unsigned HS_POL    = 0,
   parameter int unsigned VS_POL    = 0,
   parameter int unsigned CLK_DIV   = 2,
   parameter int unsigned SOG       = 0,
   parameter int unsigned CNT_W     = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   output logic             pix_en,
   output logic             h_sync,
   output logic             v_sync,
   output logic             blank_n,
   output logic             sync_n,
   output logic             active,
   output logic [CNT_W-1:0] posx,
   output logic [CNT_W-1:0] posy,
   output logic             line_start,
   output logic             frame_start
);

   localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
   localparam int unsigned VS_END   = VS_START + V_SYNC;
   localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic        HS_ACT   = 1'(HS_POL);
   localparam logic        VS_ACT   = 1'(VS_POL);
   localparam logic        SOG_EN   = 1'(SOG);

   logic [DIV_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] hc_q, hc_d;
   logic [CNT_W-1:0] vc_q, vc_d;
   logic             hs_q, hs_d;
   logic             vs_q, vs_d;
   logic             act_q, act_d;
   logic             syn_q, syn_d;
   logic             h_in, v_in;

   // Strobes and next state; decoded levels look at the counts after this edge
   always_comb begin
      div_d       = div_q;
      hc_d        = hc_q;
      vc_d        = vc_q;
      pix_en      = enable & (div_q == DIV_W'(CLK_DIV - 1));
      line_start  = pix_en & (hc_q == CNT_W'(H_TOTAL - 1));
      frame_start = line_start & (vc_q == CNT_W'(V_TOTAL - 1));

      if (enable) begin
         div_d = pix_en ? '0 : div_q + DIV_W'(1);
      end
      if (pix_en) begin
         if (hc_q == CNT_W'(H_TOTAL - 1)) begin
            hc_d = '0;
            vc_d = (vc_q == CNT_W'(V_TOTAL - 1)) ? '0 : vc_q + CNT_W'(1);
         end else begin
            hc_d = hc_q + CNT_W'(1);
         end
      end

      h_in  = (hc_d >= CNT_W'(HS_START)) && (hc_d < CNT_W'(HS_END));
      v_in  = (vc_d >= CNT_W'(VS_START)) && (vc_d < CNT_W'(VS_END));
      hs_d  = h_in ? HS_ACT : ~HS_ACT;
      vs_d  = v_in ? VS_ACT : ~VS_ACT;
      act_d = (hc_d < CNT_W'(H_DISPLAY)) && (vc_d < CNT_W'(V_DISPLAY));
      syn_d = SOG_EN ? ~(h_in | v_in) : 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q <= '0;
         hc_q  <= '0;
         vc_q  <= '0;
         hs_q  <= ~HS_ACT;
         vs_q  <= ~VS_ACT;
         act_q <= 1'b1;
         syn_q <= 1'b1;
      end else begin
         div_q <= div_d;
         hc_q  <= hc_d;
         vc_q  <= vc_d;
         hs_q  <= hs_d;
         vs_q  <= vs_d;
         act_q <= act_d;
         syn_q <= syn_d;
      end
   end

   assign posx    = hc_q;
   assign posy    = vc_q;
   assign h_sync  = hs_q;
   assign v_sync  = vs_q;
   assign blank_n = act_q;
   assign active  = act_q;
   assign sync_n  = syn_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three parameter sets checked every cycle against an
// arithmetic raster model driven by a count of enabled clock edges.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic rst;
   logic enable;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit running = 1'b0;
   longint e;

   logic pe0, hs0, vs0, bn0, sn0, ac0, ls0, fs0;
   logic [9:0] px0, py0;
   logic pe1, hs1, vs1, bn1, sn1, ac1, ls1, fs1;
   logic [3:0] px1, py1;
   logic pe2, hs2, vs2, bn2, sn2, ac2, ls2, fs2;
   logic [3:0] px2, py2;

   vga_timing_gen u_d0 (
      .clk(clk), .rst(rst), .enable(enable), .pix_en(pe0), .h_sync(hs0), .v_sync(vs0),
      .blank_n(bn0), .sync_n(sn0), .active(ac0), .posx(px0), .posy(py0),
      .line_start(ls0), .frame_start(fs0));

   vga_timing_gen #(
      .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
      .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
      .HS_POL(1), .VS_POL(0), .CLK_DIV(1), .SOG(1), .CNT_W(4)
   ) u_d1 (
      .clk(clk), .rst(rst), .enable(enable), .pix_en(pe1), .h_sync(hs1), .v_sync(vs1),
      .blank_n(bn1), .sync_n(sn1), .active(ac1), .posx(px1), .posy(py1),
      .line_start(ls1), .frame_start(fs1));

   vga_timing_gen #(
      .H_DISPLAY(5), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
      .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
      .HS_POL(0), .VS_POL(1), .CLK_DIV(3), .SOG(1), .CNT_W(4)
   ) u_d2 (
      .clk(clk), .rst(rst), .enable(enable), .pix_en(pe2), .h_sync(hs2), .v_sync(vs2),
      .blank_n(bn2), .sync_n(sn2), .active(ac2), .posx(px2), .posy(py2),
      .line_start(ls2), .frame_start(fs2));

   // Enabled clk edges since reset; every output is a function of this count
   always @(posedge clk or posedge rst) begin
      if (rst) e <= 0;
      else if (enable) e <= e + 1;
   end

   function automatic logic [27:0] model(longint ec, logic en, int hd, int hf, int hsw, int hb,
                                         int vd, int vf, int vsw, int vb, int hp, int vp,
                                         int d, int sog);
      int ht, vt, hc, vc, dv;
      longint pix;
      logic pe, ls, fs, act, hin, vin, hsy, vsy, sn;
      ht  = hd + hf + hsw + hb;
      vt  = vd + vf + vsw + vb;
      pix = ec / d;
      dv  = int'(ec % d);
      hc  = int'(pix % ht);
      vc  = int'((pix / ht) % vt);
      pe  = en && (dv == d - 1);
      ls  = pe && (hc == ht - 1);
      fs  = ls && (vc == vt - 1);
      act = (hc < hd) && (vc < vd);
      hin = (hc >= hd + hf) && (hc < hd + hf + hsw);
      vin = (vc >= vd + vf) && (vc < vd + vf + vsw);
      hsy = hin ? (hp != 0) : (hp == 0);
      vsy = vin ? (vp != 0) : (vp == 0);
      sn  = (sog != 0) ? !(hin || vin) : 1'b1;
      return {pe, hsy, vsy, act, sn, act, ls, fs, 10'(hc), 10'(vc)};
   endfunction

   task automatic cmp_vec(string name, logic [27:0] got, logic [27:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
      end
   endtask

   task automatic chk(string name, int got, int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, got, exp);
      end
   endtask

   // Per-cycle comparison of all three instances against the model
   always @(negedge clk) begin
      if (running) begin
         cmp_vec("d0", {pe0, hs0, vs0, bn0, sn0, ac0, ls0, fs0, px0, py0},
                 model(e, enable, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 2, 0));
         cmp_vec("d1", {pe1, hs1, vs1, bn1, sn1, ac1, ls1, fs1, 10'(px1), 10'(py1)},
                 model(e, enable, 8, 2, 2, 2, 4, 1, 1, 1, 1, 0, 1, 1));
         cmp_vec("d2", {pe2, hs2, vs2, bn2, sn2, ac2, ls2, fs2, 10'(px2), 10'(py2)},
                 model(e, enable, 5, 1, 2, 1, 3, 1, 2, 1, 0, 1, 3, 1));
      end
   end

   initial begin
      int nls, pe_cnt, pe_mark, hs_low, blank_x, hs_x, cyc, ls1_last, fs1_last;
      int nls1, nfs1;
      bit found;
      rst = 1'b0;
      enable = 1'b0;
      #1 rst = 1'b1;
      running = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_posx", int'(px0), 0);
      chk("rst_hsync", int'(hs0), 1);
      chk("rst_blank", int'(bn0), 1);
      chk("rst_pix_en_div2", int'(pe0), 0);
      chk("rst_sync_n_sog", int'(sn1), 1);
      enable = 1'b1;
      #1 chk("rst_pix_en_div1", int'(pe1), 1);
      @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #2;
      chk("edge1_pix_en", int'(pe0), 1);
      chk("edge1_posx", int'(px0), 0);
      chk("edge1_vsync", int'(vs0), 1);
      @(posedge clk);
      #2;
      chk("edge2_posx", int'(px0), 1);
      chk("edge2_pix_en", int'(pe0), 0);

      // Two full default lines; many small frames on d1
      nls = 0; pe_cnt = 0; pe_mark = 0; hs_low = 0; blank_x = -1; hs_x = -1;
      cyc = 0; ls1_last = 0; fs1_last = 0; nls1 = 0; nfs1 = 0;
      for (int i = 0; i < 3400; i++) begin
         @(negedge clk);
         cyc++;
         if (pe0) pe_cnt++;
         if (nls == 1 && !hs0) hs_low++;
         if (blank_x < 0 && !bn0) blank_x = int'(px0);
         if (hs_x < 0 && !hs0) hs_x = int'(px0);
         if (ls0) begin
            nls++;
            if (nls == 1) begin
               pe_mark = pe_cnt;
               chk("ls_posx", int'(px0), 799);
            end else if (nls == 2) begin
               chk("line_pix_en", pe_cnt - pe_mark, 800);
               chk("line_hsync_low_clk", hs_low, 192);
               chk("ls2_posy", int'(py0), 1);
            end
         end
         if (ls1) begin
            nls1++;
            if (nls1 == 2) chk("d1_line_period", cyc - ls1_last, 14);
            ls1_last = cyc;
         end
         if (fs1) begin
            nfs1++;
            if (nfs1 == 1) begin
               chk("d1_fs_posx", int'(px1), 13);
               chk("d1_fs_posy", int'(py1), 6);
            end
            if (nfs1 == 2) chk("d1_frame_period", cyc - fs1_last, 98);
            fs1_last = cyc;
         end
      end
      chk("line_count", nls, 2);
      chk("blank_fall_x", blank_x, 640);
      chk("hsync_start_x", hs_x, 656);

      // Freeze for 37 clk on the second clk of pixel 300
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         @(negedge clk);
         if (px0 == 10'd300 && !pe0) found = 1'b1;
      end
      chk("find_posx300", int'(found), 1);
      @(posedge clk);
      #2 enable = 1'b0;
      for (int i = 0; i < 37; i++) begin
         @(negedge clk);
         chk("freeze_posx", int'(px0), 300);
         chk("freeze_strobes", int'({pe0, ls0, fs0, pe1, ls1, fs1}), 0);
      end
      @(posedge clk);
      #2 enable = 1'b1;
      @(posedge clk);
      #2 chk("resume_posx", int'(px0), 301);

      // Asynchronous reset inside the h_sync region
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         @(negedge clk);
         if (px0 == 10'd700) found = 1'b1;
      end
      chk("find_posx700", int'(found), 1);
      chk("pre_rst_hsync", int'(hs0), 0);
      #2 rst = 1'b1;
      #1;
      chk("async_posx", int'(px0), 0);
      chk("async_posy", int'(py0), 0);
      chk("async_hsync", int'(hs0), 1);
      chk("async_blank", int'(bn0), 1);
      @(posedge clk);
      #2 rst = 1'b0;

      // Random enable with occasional mid-frame resets
      for (int i = 0; i < 15000; i++) begin
         @(posedge clk);
         #2 enable = ($urandom_range(0, 7) != 0);
         if (rst) rst = 1'b0;
         else if ($urandom_range(0, 399) == 0) begin
            #1 rst = 1'b1;
         end
      end
      @(negedge clk);
      running = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
